// File: rtl/d_ff.sv
// d_ff: positive-edge D-type register with synchronous active-low reset,
// clock enable and a complementary output. WIDTH=1 gives a plain DFF.
// EN is normally tied to 1'b1 for plain DFF behaviour.
module d_ff #(
   parameter int unsigned           WIDTH   = 1,
   parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
   input  logic             CK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QN
);

   // Reject widths outside the supported range at elaboration time.
   if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
      $error("d_ff: WIDTH must be in 1..64");
   end

   // State register: reset takes priority over enable; otherwise hold.
   always_ff @(posedge CK) begin
      if (!RST_N) begin
         Q <= RST_VAL;
      end else if (EN) begin
         Q <= D;
      end
   end

   // Complement is derived directly from Q, no second register.
   assign QN = ~Q;

endmodule

// File: tb/tb_d_ff.sv
// tb_d_ff: directed, table-driven checks of d_ff in three configurations
// (1-bit reset-to-0, 1-bit reset-to-1, 8-bit reset-to-A5).
module tb_d_ff;

   logic       ck = 1'b0;
   logic       rst_n, en, d;
   logic       q1, qn1, q2, qn2;
   logic       r8, e8;
   logic [7:0] d8, q8, qn8;

   int checks = 0;
   int errors = 0;

   // 20 ns period, first rising edge at 10 ns.
   always #10 ck = ~ck;

   d_ff #(.WIDTH(1), .RST_VAL(1'b0)) u_d0 (
      .CK(ck), .RST_N(rst_n), .EN(en), .D(d), .Q(q1), .QN(qn1));

   d_ff #(.WIDTH(1), .RST_VAL(1'b1)) u_d1 (
      .CK(ck), .RST_N(rst_n), .EN(en), .D(d), .Q(q2), .QN(qn2));

   d_ff #(.WIDTH(8), .RST_VAL(8'hA5)) u_d8 (
      .CK(ck), .RST_N(r8), .EN(e8), .D(d8), .Q(q8), .QN(qn8));

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   typedef struct {
      time  t;
      logic d;
   } stim_t;

   typedef struct {
      time  t;
      logic q;
   } wexp_t;

   typedef struct {
      logic rst_n;
      logic en;
      logic d;
      logic q1;
      logic q2;
   } vec_t;

   stim_t wstim [10];
   wexp_t wexp  [11];
   vec_t  vecs  [11];

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      wstim[0] = '{0,   1'b0}; wstim[1] = '{20,  1'b1}; wstim[2] = '{40,  1'b0};
      wstim[3] = '{65,  1'b1}; wstim[4] = '{85,  1'b0}; wstim[5] = '{115, 1'b1};
      wstim[6] = '{135, 1'b0}; wstim[7] = '{155, 1'b1}; wstim[8] = '{165, 1'b0};
      wstim[9] = '{195, 1'b1};

      wexp[0]  = '{10,  1'b0}; wexp[1]  = '{30,  1'b1}; wexp[2]  = '{50,  1'b0};
      wexp[3]  = '{70,  1'b1}; wexp[4]  = '{90,  1'b0}; wexp[5]  = '{110, 1'b0};
      wexp[6]  = '{130, 1'b1}; wexp[7]  = '{150, 1'b0}; wexp[8]  = '{170, 1'b0};
      wexp[9]  = '{190, 1'b0}; wexp[10] = '{210, 1'b1};

      //            rst_n en    d     q1    q2
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};  // reset beats EN and D
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};  // hold 1
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};  // hold 2
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};  // hold 3
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // enable resumes capture
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};  // reset with EN=0
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};  // hold reset value
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      rst_n = 1'b0;
      en    = 1'b1;
      d     = 1'b0;
      r8    = 1'b0;
      e8    = 1'b1;
      d8    = 8'h00;

      // Waveform capture: absolute-time D stimulus, Q checked just after each
      // rising edge and again late in the cycle (after the falling edge and
      // any mid-cycle D changes) to catch non-edge updates.
      fork
         begin
            #15 rst_n = 1'b1;
         end
         begin
            for (int i = 0; i < 10; i++) begin
               #(wstim[i].t - $time);
               d = wstim[i].d;
            end
         end
         begin
            for (int i = 0; i < 11; i++) begin
               #(wexp[i].t + 2 - $time);
               chk("wave_q_early", {7'd0, q1}, {7'd0, wexp[i].q});
               chk("wave_qn_early", {7'd0, qn1}, {7'd0, ~wexp[i].q});
               if (i == 0) chk("wave_rst1_q", {7'd0, q2}, 8'd1);
               #16;
               chk("wave_q_late", {7'd0, q1}, {7'd0, wexp[i].q});
            end
         end
      join

      // Table-driven synchronous vectors: drive on falling edge, check after rise.
      for (int i = 0; i < 11; i++) begin
         @(negedge ck);
         rst_n = vecs[i].rst_n;
         en    = vecs[i].en;
         d     = vecs[i].d;
         @(posedge ck);
         #2;
         chk("vec_q1", {7'd0, q1}, {7'd0, vecs[i].q1});
         chk("vec_qn1", {7'd0, qn1}, {7'd0, ~vecs[i].q1});
         chk("vec_q2", {7'd0, q2}, {7'd0, vecs[i].q2});
         chk("vec_qn2", {7'd0, qn2}, {7'd0, ~vecs[i].q2});
      end

      // Reset pulse entirely between edges must be ignored (Q is 1 here).
      @(negedge ck);
      rst_n = 1'b0;
      #3;
      chk("rst_glitch_mid", {7'd0, q1}, 8'd1);
      rst_n = 1'b1;
      @(posedge ck);
      #2;
      chk("rst_glitch_q1", {7'd0, q1}, 8'd1);
      chk("rst_glitch_q2", {7'd0, q2}, 8'd1);

      // Reset asserted mid-cycle acts only at the next edge; release mid-cycle
      // leaves Q at the reset value until the following edge loads D.
      #3;
      rst_n = 1'b0;
      #2;
      chk("rst_assert_wait", {7'd0, q1}, 8'd1);
      @(posedge ck);
      #2;
      chk("rst_assert_edge", {7'd0, q1}, 8'd0);
      #3;
      rst_n = 1'b1;
      #2;
      chk("rst_release_wait", {7'd0, q1}, 8'd0);
      chk("rst_release_wait2", {7'd0, q2}, 8'd1);
      d = 1'b0;
      @(posedge ck);
      #2;
      chk("rst_release_load1", {7'd0, q1}, 8'd0);
      chk("rst_release_load2", {7'd0, q2}, 8'd0);

      // 8-bit register: reset value, capture, hold.
      @(negedge ck);
      r8 = 1'b0; e8 = 1'b1; d8 = 8'hFF;
      @(posedge ck);
      #2;
      chk("w8_rst_q", q8, 8'hA5);
      chk("w8_rst_qn", qn8, 8'h5A);
      @(negedge ck);
      r8 = 1'b1; d8 = 8'h3C;
      #2;
      chk("w8_no_early", q8, 8'hA5);
      @(posedge ck);
      #2;
      chk("w8_load_q", q8, 8'h3C);
      chk("w8_load_qn", qn8, 8'hC3);
      @(negedge ck);
      e8 = 1'b0; d8 = 8'h00;
      @(posedge ck);
      #2;
      chk("w8_hold", q8, 8'h3C);
      @(negedge ck);
      e8 = 1'b1; d8 = 8'h96;
      @(posedge ck);
      #2;
      chk("w8_load2", q8, 8'h96);
      chk("w8_load2_qn", qn8, 8'h69);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
